// File: rtl/dsi_lane_gen2.sv
// rtl/dsi_lane_gen2.sv - second-generation D-PHY lane controller (HS burst + LP escape/ULPS)
// Ports:
//   clk, rst_n                  byte clock, synchronous active-low reset
//   lines_enable                lane powered/enabled
//   mode_lp, esc_cmd            burst type / escape command, sampled with start_rqst
//   start_rqst, fin_rqst        start a burst / mark the accepted beat as last
//   ulps_exit_rqst              leave ULPS
//   inp_data, data_rqst         pull-style payload (LP uses [7:0])
//   *_val, ulps_wakeup_val      timeouts in clk cycles (0 behaves as 1)
//   hs_output, hs_enable        HS word and driver enable
//   lp_p, lp_n, lp_lines_enable LP line levels and driver enable
//   active, lane_ready, in_ulps status
module dsi_lane_gen2 #(
  parameter int MODE   = 0,
  parameter int BYTES  = 1,
  parameter int TMR_W  = 8,
  parameter int WAKE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lines_enable,
  input  logic                 mode_lp,
  input  logic                 esc_cmd,
  input  logic                 start_rqst,
  input  logic                 fin_rqst,
  input  logic                 ulps_exit_rqst,
  input  logic [8*BYTES-1:0]   inp_data,
  output logic                 data_rqst,
  input  logic [TMR_W-1:0]     tlpx_val,
  input  logic [TMR_W-1:0]     hs_prepare_val,
  input  logic [TMR_W-1:0]     hs_zero_val,
  input  logic [TMR_W-1:0]     hs_trail_val,
  input  logic [TMR_W-1:0]     hs_exit_val,
  input  logic [TMR_W-1:0]     lp_baud_val,
  input  logic [WAKE_W-1:0]    ulps_wakeup_val,
  output logic [8*BYTES-1:0]   hs_output,
  output logic                 hs_enable,
  output logic                 lp_p,
  output logic                 lp_n,
  output logic                 lp_lines_enable,
  output logic                 active,
  output logic                 lane_ready,
  output logic                 in_ulps
);
  localparam int W  = 8 * BYTES;
  localparam int CW = (WAKE_W > TMR_W) ? WAKE_W : TMR_W;

  typedef enum logic [3:0] {
    S_DISABLED, S_INIT, S_IDLE, S_HS_RQST, S_HS_PREP, S_HS_ZERO, S_HS_SYNC, S_HS_DATA,
    S_HS_TRAIL, S_HS_EXIT, S_ESC_SEQ, S_ESC_CMD, S_LP_DATA, S_ESC_MARK, S_ULPS, S_ULPS_WAKE
  } state_t;

  // Counters load val-1 so a state lasts val cycles; 0 is clamped to 1 cycle.
  function automatic logic [CW-1:0] ld_t(input logic [TMR_W-1:0] v);
    ld_t = (v == '0) ? '0 : CW'(v - TMR_W'(1));
  endfunction

  function automatic logic [CW-1:0] ld_w(input logic [WAKE_W-1:0] v);
    ld_w = (v == '0) ? '0 : CW'(v - WAKE_W'(1));
  endfunction

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt, per, nxt_per;
  logic [1:0]      sub, nxt_sub;
  logic [2:0]      bit_i, nxt_bit;
  logic            half, nxt_half;
  logic [7:0]      sh, nxt_sh;
  logic            fin_lp, nxt_fin_lp, fin_seen, nxt_fin_seen;
  logic            esc_ulps, nxt_ulps, last_msb, nxt_last_msb;
  logic            tmo;

  // Next-state logic. `per` holds the reload value for the ESC_SEQ phases
  // (tlpx) and later for the spaced-one-hot half-symbols (baud).
  always_comb begin
    nxt_state = state;     nxt_cnt = cnt;       nxt_per = per;
    nxt_sub = sub;         nxt_bit = bit_i;     nxt_half = half;
    nxt_sh = sh;           nxt_fin_lp = fin_lp; nxt_fin_seen = fin_seen;
    nxt_ulps = esc_ulps;   nxt_last_msb = last_msb;
    tmo = (cnt == '0);
    case (state)
      S_DISABLED: if (lines_enable) begin nxt_state = S_INIT; nxt_cnt = ld_t(tlpx_val); end
      S_INIT:     if (tmo) nxt_state = S_IDLE; else nxt_cnt = cnt - CW'(1);
      S_IDLE: begin
        if (!lines_enable) nxt_state = S_DISABLED;
        else if (start_rqst) begin
          nxt_cnt = ld_t(tlpx_val);
          if (MODE == 1 || !mode_lp) nxt_state = S_HS_RQST;
          else begin
            nxt_state = S_ESC_SEQ; nxt_per = ld_t(tlpx_val); nxt_sub = 2'd0; nxt_ulps = esc_cmd;
          end
        end
      end
      S_HS_RQST: if (tmo) begin nxt_state = S_HS_PREP; nxt_cnt = ld_t(hs_prepare_val); end
                 else nxt_cnt = cnt - CW'(1);
      S_HS_PREP: if (tmo) begin nxt_state = S_HS_ZERO; nxt_cnt = ld_t(hs_zero_val); end
                 else nxt_cnt = cnt - CW'(1);
      S_HS_ZERO: begin
        if (!tmo) nxt_cnt = cnt - CW'(1);
        else if (MODE == 1) begin nxt_state = S_HS_DATA; nxt_fin_seen = 1'b0; nxt_last_msb = 1'b1; end
        else nxt_state = S_HS_SYNC;
      end
      S_HS_SYNC: begin
        nxt_state = S_HS_DATA; nxt_fin_seen = fin_rqst; nxt_last_msb = inp_data[W-1];
      end
      S_HS_DATA: begin
        // MODE=0: after the fin beat is accepted, one more cycle shows it before the trail.
        if (MODE == 1 ? fin_rqst : fin_seen) begin
          nxt_state = S_HS_TRAIL; nxt_cnt = ld_t(hs_trail_val);
        end else if (MODE == 0) begin
          nxt_fin_seen = fin_rqst; nxt_last_msb = inp_data[W-1];
        end
      end
      S_HS_TRAIL: if (tmo) begin nxt_state = S_HS_EXIT; nxt_cnt = ld_t(hs_exit_val); end
                  else nxt_cnt = cnt - CW'(1);
      S_HS_EXIT:  if (tmo) nxt_state = S_IDLE; else nxt_cnt = cnt - CW'(1);
      S_ESC_SEQ: begin
        if (!tmo) nxt_cnt = cnt - CW'(1);
        else if (sub != 2'd3) begin nxt_sub = sub + 2'd1; nxt_cnt = per; end
        else begin
          nxt_state = S_ESC_CMD; nxt_per = ld_t(lp_baud_val); nxt_cnt = ld_t(lp_baud_val);
          nxt_bit = 3'd0; nxt_half = 1'b0;
        end
      end
      S_ESC_CMD, S_LP_DATA: begin
        if (!tmo) nxt_cnt = cnt - CW'(1);
        else if (!half) begin nxt_half = 1'b1; nxt_cnt = per; end
        else if (bit_i != 3'd7) begin nxt_bit = bit_i + 3'd1; nxt_half = 1'b0; nxt_cnt = per; end
        else if (state == S_ESC_CMD && esc_ulps) nxt_state = S_ULPS;
        else if (state == S_LP_DATA && fin_lp) begin
          nxt_state = S_ESC_MARK; nxt_cnt = ld_t(tlpx_val);
        end else begin
          nxt_state = S_LP_DATA; nxt_sh = inp_data[7:0]; nxt_fin_lp = fin_rqst;
          nxt_bit = 3'd0; nxt_half = 1'b0; nxt_cnt = per;
        end
      end
      S_ESC_MARK: if (tmo) nxt_state = S_IDLE; else nxt_cnt = cnt - CW'(1);
      S_ULPS: begin
        if (!lines_enable) nxt_state = S_DISABLED;
        else if (ulps_exit_rqst) begin nxt_state = S_ULPS_WAKE; nxt_cnt = ld_w(ulps_wakeup_val); end
      end
      S_ULPS_WAKE: if (tmo) begin nxt_state = S_INIT; nxt_cnt = ld_t(tlpx_val); end
                   else nxt_cnt = cnt - CW'(1);
      default: nxt_state = S_DISABLED;
    endcase
  end

  // Output decode from the next-state values so every output is registered
  // and changes on the same edge as the state.
  logic [1:0]   o_lp;
  logic         o_lpen, o_hsen, o_dr, o_bit, o_sym_last;
  logic [W-1:0] o_hs;
  logic [7:0]   o_cmd;

  always_comb begin
    o_lp = 2'b00; o_lpen = 1'b1; o_hsen = 1'b0; o_hs = '0; o_dr = 1'b0;
    o_cmd = nxt_ulps ? 8'h1E : 8'hE1;
    o_bit = (nxt_state == S_ESC_CMD) ? o_cmd[3'd7 - nxt_bit] : nxt_sh[nxt_bit];
    o_sym_last = nxt_half && (nxt_bit == 3'd7) && (nxt_cnt == '0);
    case (nxt_state)
      S_DISABLED: o_lpen = 1'b0;
      S_INIT, S_IDLE, S_HS_EXIT: o_lp = 2'b11;
      S_HS_RQST: o_lp = 2'b01;
      S_HS_ZERO: begin o_lpen = 1'b0; o_hsen = 1'b1; end
      S_HS_SYNC: begin o_lpen = 1'b0; o_hsen = 1'b1; o_hs[W-1 -: 8] = 8'hB8; o_dr = 1'b1; end
      S_HS_DATA: begin
        o_lpen = 1'b0; o_hsen = 1'b1;
        o_hs   = (MODE == 1) ? {BYTES{8'hAA}} : inp_data;
        o_dr   = (MODE == 0) && !nxt_fin_seen;
      end
      S_HS_TRAIL: begin o_lpen = 1'b0; o_hsen = 1'b1; o_hs = {W{~nxt_last_msb}}; end
      S_ESC_SEQ: o_lp = (nxt_sub == 2'd0) ? 2'b10 : (nxt_sub == 2'd2) ? 2'b01 : 2'b00;
      S_ESC_CMD, S_LP_DATA: begin
        o_lp = nxt_half ? 2'b00 : (o_bit ? 2'b10 : 2'b01);
        o_dr = o_sym_last && ((nxt_state == S_ESC_CMD) ? !nxt_ulps : !nxt_fin_lp);
      end
      S_ESC_MARK, S_ULPS_WAKE: o_lp = 2'b10;
      default: o_lp = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_DISABLED; cnt <= '0; per <= '0; sub <= '0; bit_i <= '0; half <= 1'b0;
      sh <= '0; fin_lp <= 1'b0; fin_seen <= 1'b0; esc_ulps <= 1'b0; last_msb <= 1'b0;
      hs_output <= '0; hs_enable <= 1'b0; lp_p <= 1'b0; lp_n <= 1'b0; lp_lines_enable <= 1'b0;
      data_rqst <= 1'b0; active <= 1'b0; lane_ready <= 1'b0; in_ulps <= 1'b0;
    end else begin
      state <= nxt_state; cnt <= nxt_cnt; per <= nxt_per; sub <= nxt_sub; bit_i <= nxt_bit;
      half <= nxt_half; sh <= nxt_sh; fin_lp <= nxt_fin_lp; fin_seen <= nxt_fin_seen;
      esc_ulps <= nxt_ulps; last_msb <= nxt_last_msb;
      hs_output <= o_hs; hs_enable <= o_hsen; {lp_p, lp_n} <= o_lp; lp_lines_enable <= o_lpen;
      data_rqst <= o_dr;
      active     <= (nxt_state == S_HS_DATA) || (nxt_state == S_LP_DATA);
      lane_ready <= (nxt_state == S_IDLE);
      in_ulps    <= (nxt_state == S_ULPS);
    end
  end
endmodule

// File: doc/dsi_lane_gen2.md
Name: dsi_lane_gen2

Overview:
Parametrised second-generation D-PHY lane controller. It drives one data or clock lane from a byte-parallel HS datapath BYTES bytes wide and a spaced-one-hot LP escape engine. Compared with the first-generation lane it adds an internal HS-zero/sync/trail sequencer, a runtime LP baud rate, a selectable escape command (LPDT or ULPS) and ULPS exit/wake-up. It sits between the packet assembler (pull interface) and the PHY serializer/LP drivers.

Parameters:
MODE, 0, 0 = data lane; 1 = clock lane (no sync byte, no LP escape, HS pattern 0xAA per byte).
BYTES, 1, HS bytes per clk cycle (1, 2 or 4). byte0 = earliest in time. Bit 0 of each byte is first on the wire.
TMR_W, 8, width of the tlpx/prepare/zero/trail/exit/baud timeout inputs.
WAKE_W, 16, width of ulps_wakeup_val.

Ports:
clk  in  1  lane byte clock
rst_n  in  1  reset, synchronous, active-low
lines_enable  in  1  1 = lane powered/enabled
mode_lp  in  1  sampled with start_rqst: 0 = HS burst, 1 = LP escape
esc_cmd  in  1  sampled with start_rqst when mode_lp=1: 0 = LPDT (0xE1), 1 = ULPS (0x1E)
start_rqst  in  1  request a burst; honoured in IDLE only
fin_rqst  in  1  qualifies the beat accepted this cycle as the last one
ulps_exit_rqst  in  1  leave ULPS
inp_data  in  8*BYTES  payload; LP uses [7:0] only
data_rqst  out  1  inp_data is consumed on this cycle's edge
tlpx_val, hs_prepare_val, hs_zero_val, hs_trail_val, hs_exit_val, lp_baud_val  in  TMR_W  timeouts in clk cycles
ulps_wakeup_val  in  WAKE_W  ULPS mark-1 duration in clk cycles
hs_output  out  8*BYTES  HS byte word to the serializer
hs_enable  out  1  HS driver enable
lp_p, lp_n  out  1  LP line levels
lp_lines_enable  out  1  LP driver enable
active  out  1  high in HS_DATA or LP_DATA
lane_ready  out  1  high in IDLE
in_ulps  out  1  high in ULPS

Behaviour:
- Reset (rst_n=0 at an edge): state = DISABLED. All outputs are 0 on the next cycle. This applies mid-burst too; there is no graceful trail.
- Timers: each timed state lasts exactly max(val,1) cycles. The counter loads val-1 on state entry; val=0 is treated as 1. Timeout values are sampled on state entry only.
- LP pin pair {lp_p,lp_n} is registered and updates on the same edge as the state change. lp_lines_enable = 0 in DISABLED and in HS_ZERO/HS_SYNC/HS_DATA/HS_TRAIL.
- States and transitions:
  - DISABLED (LP-00, drivers off) -> INIT when lines_enable.
  - INIT (LP-11, tlpx) -> IDLE.
  - IDLE (LP-11):
    - !lines_enable -> DISABLED. This has priority over start_rqst.
    - start_rqst&!mode_lp -> HS_RQST.
    - start_rqst&mode_lp -> ESC_SEQ. With MODE=1, mode_lp is ignored and the HS path is taken.
  - HS_RQST (LP-01, tlpx) -> HS_PREP (LP-00, hs_prepare) -> HS_ZERO.
  - HS_ZERO: hs_enable=1, output all-zero, hs_zero cycles -> HS_SYNC (MODE=0) or HS_DATA (MODE=1).
  - HS_SYNC: one cycle. Top byte = 0xB8, lower bytes = 0x00. data_rqst=1 this cycle, so the first beat is accepted here -> HS_DATA.
  - HS_DATA: data_rqst=1 every cycle (MODE=0). A beat accepted at edge N appears on hs_output in cycle N+1. A beat accepted with fin_rqst=1 is the last one -> HS_TRAIL. In MODE=1 the output is 0xAA per byte and fin_rqst alone ends the state.
  - HS_TRAIL: hs_trail cycles. Every bit equals the inverse of bit 8*BYTES-1 of the last word -> HS_EXIT.
  - HS_EXIT (LP-11, hs_enable=0, hs_output=0, hs_exit) -> IDLE.
  - ESC_SEQ: LP-10, LP-00, LP-01, LP-00, each tlpx cycles -> ESC_CMD.
  - ESC_CMD: sends the 8-bit command MSB first, spaced-one-hot.
    - A 1 bit is LP-10 for baud cycles, then LP-00 for baud cycles.
    - A 0 bit is LP-01 for baud cycles, then LP-00 for baud cycles.
    - Here baud = max(lp_baud_val,1).
    - Exit: LPDT -> LP_DATA; ULPS -> ULPS.
  - LP_DATA:
    - data_rqst is a 1-cycle pulse on the last cycle of ESC_CMD and on the last cycle of each data byte. That byte's inp_data[7:0] is latched and sent LSB first.
    - A byte requested with fin_rqst=1 is sent, then -> ESC_MARK.
  - ESC_MARK (LP-10, tlpx) -> IDLE.
  - ULPS (LP-00, in_ulps=1): ulps_exit_rqst -> ULPS_WAKE. lines_enable=0 -> DISABLED, with priority over ulps_exit_rqst.
  - ULPS_WAKE (LP-10, ulps_wakeup_val, 0 treated as 1) -> INIT.
- data_rqst is 0 outside HS_SYNC/HS_DATA (MODE=0) and the LP_DATA request pulses.
- Ignored inputs:
  - start_rqst outside IDLE.
  - fin_rqst when no beat is accepted that cycle.
  - ulps_exit_rqst outside ULPS.
  - lines_enable drop outside IDLE/ULPS: the burst completes first, then the drop takes effect from IDLE.
- Width rules: all timer decrements are modulo TMR_W / WAKE_W. No saturation is needed because counters load val-1 with a 0->1 clamp.

Test Plan:
1. Bring-up: reset, lines_enable=1, tlpx=4 -> LP-00 until enable, then LP-11 for 4 cycles, then lane_ready=1 on cycle 6.
2. HS burst, BYTES=2, tlpx=3, prep=2, zero=5, trail=4, exit=3, 3 beats 0x1234/0x5678/0x8ABC (fin on the 3rd):
   - LP-01 for 3 cycles, LP-00 for 2, zeros for 5.
   - Sync word 0xB800, then 0x1234, 0x5678, 0x8ABC.
   - 4 cycles of 0x0000 (MSB of 0x8ABC is 1).
   - LP-11 for 3 cycles, then lane_ready.
3. LPDT, lp_baud=2, 2 bytes 0xA5,0x3C (fin on 2nd):
   - ESC_SEQ 10/00/01/00.
   - Command bits 1,1,1,0,0,0,0,1 as 4-cycle symbols.
   - 0xA5 LSB first (1,0,1,0,0,1,0,1), then 0x3C.
   - Mark LP-10 for tlpx, then LP-11.
   - Exactly 2 data_rqst pulses.
4. ULPS: esc_cmd=1 -> command 0x1E sent, then in_ulps=1 with LP-00. ulps_exit_rqst with wakeup=20 -> LP-10 for 20 cycles, LP-11 for tlpx, then IDLE.
5. Zero timeouts: all vals = 0 -> every timed state lasts 1 cycle; HS burst of 1 beat completes with no hang.
6. Mid-burst reset during HS_DATA and during ESC_CMD -> next cycle all outputs 0 and state DISABLED. lines_enable=0 together with start_rqst in IDLE -> DISABLED, no burst.
